// File: rtl/load_store_unit_if.sv
// load_store_unit_if
//   Bundles the execute-side request/response handshake and the data-memory
//   bus of the load/store unit.
//   Modports:
//     slave  - the LSU: receives requests and read data; drives ready, the
//              response and the memory strobes, address and write data.
//     master - the environment: execute/writeback side plus the memory.
//   Signals:
//     req_valid/req_ready/req_is_store/req_funct3/req_base/req_offset/req_wdata
//     resp_valid/resp_ready/resp_rdata/resp_err
//     mem_base/mem_offset/mem_r_enabled/mem_r_data/mem_w_enabled/mem_w_data
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base;
    logic [31:0] req_offset;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_base;
    logic [31:0] mem_offset;
    logic        mem_r_enabled;
    logic [31:0] mem_r_data;
    logic        mem_w_enabled;
    logic [31:0] mem_w_data;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_base, req_offset, req_wdata,
        input  resp_ready, mem_r_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_base, mem_offset, mem_r_enabled, mem_w_enabled, mem_w_data
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_base, req_offset, req_wdata,
        output resp_ready, mem_r_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_base, mem_offset, mem_r_enabled, mem_w_enabled, mem_w_data
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
//   Load/store unit between execute and a word-only data memory with a
//   one-cycle registered read and no byte enables. Computes the effective
//   address, performs LB/LH/LW/LBU/LHU with lane extraction and extension,
//   SW as a single write and SB/SH as read-modify-write. One response per
//   request.
//   Ports:
//     clk  - clock, all state on the rising edge
//     rstn - asynchronous active-low reset
//     bus  - load_store_unit_if.slave (request, response and memory bus)
//   Parameter:
//     MEM_WORDS - number of 32-bit memory words; higher word indices error
//   Configuration macro:
//     LSU_MISALIGN_CHECK_EN - when defined, misaligned H/HU/W accesses
//     respond with an error and never touch memory; otherwise halfword and
//     word accesses are silently aligned down.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | ready for a request
//   RD    | memory read strobe asserted
//   CAP   | read data present: capture load result or build merged word
//   WR    | memory write strobe asserted
//   RESP  | response held until resp_ready
module load_store_unit #(
    parameter int MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    load_store_unit_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;

    localparam logic [30:0] MEM_WORDS_W = 31'(MEM_WORDS);

    state_t      state;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;
    logic [31:0] mem_base_q;
    logic        mem_r_enabled_q;
    logic        mem_w_enabled_q;
    logic [31:0] mem_w_data_q;

    logic [31:0] eff;
    logic        req_err;
    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign eff = bus.req_base + bus.req_offset;

    always_comb begin
        req_err = 1'b0;
        case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: req_err = 1'b0;
            3'b100, 3'b101:         req_err = bus.req_is_store;
            default:                req_err = 1'b1;
        endcase
        if ({1'b0, eff[31:2]} >= MEM_WORDS_W) begin
            req_err = 1'b1;
        end
`ifdef LSU_MISALIGN_CHECK_EN
        if ((bus.req_funct3[1:0] == 2'b01 && eff[0]) ||
            (bus.req_funct3 == 3'b010 && eff[1:0] != 2'b00)) begin
            req_err = 1'b1;
        end
`endif
    end

    // Halfwords use only eff[1] and words no lane bits, so unchecked
    // misaligned accesses fall back to the aligned-down location.
    always_comb begin
        case (funct3_q[1:0])
            2'b00:   shamt = {lane_q, 3'b000};
            2'b01:   shamt = {lane_q[1], 4'b0000};
            default: shamt = 5'd0;
        endcase
        shifted = bus.mem_r_data >> shamt;
        case (funct3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_ext = shifted;
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b101:  load_ext = {16'd0, shifted[15:0]};
            default: load_ext = 32'd0;
        endcase
    end

    always_comb begin
        merged = bus.mem_r_data;
        if (funct3_q == 3'b000) begin
            case (lane_q)
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
                default: merged = bus.mem_r_data;
            endcase
        end else if (funct3_q == 3'b001) begin
            if (lane_q[1]) merged[31:16] = wdata_q;
            else           merged[15:0]  = wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= IDLE;
            is_store_q      <= 1'b0;
            funct3_q        <= 3'd0;
            lane_q          <= 2'd0;
            wdata_q         <= 16'd0;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= 32'd0;
            resp_err_q      <= 1'b0;
            mem_base_q      <= 32'd0;
            mem_r_enabled_q <= 1'b0;
            mem_w_enabled_q <= 1'b0;
            mem_w_data_q    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        is_store_q  <= bus.req_is_store;
                        funct3_q    <= bus.req_funct3;
                        lane_q      <= eff[1:0];
                        wdata_q     <= bus.req_wdata[15:0];
                        mem_base_q  <= {eff[31:2], 2'b00};
                        req_ready_q <= 1'b0;
                        if (req_err) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'd0;
                            state        <= RESP;
                        end else if (bus.req_is_store && bus.req_funct3 == 3'b010) begin
                            mem_w_enabled_q <= 1'b1;
                            mem_w_data_q    <= bus.req_wdata;
                            state           <= WR;
                        end else begin
                            mem_r_enabled_q <= 1'b1;
                            state           <= RD;
                        end
                    end
                end
                RD: begin
                    mem_r_enabled_q <= 1'b0;
                    state           <= CAP;
                end
                CAP: begin
                    if (is_store_q) begin
                        mem_w_data_q    <= merged;
                        mem_w_enabled_q <= 1'b1;
                        state           <= WR;
                    end else begin
                        resp_rdata_q <= load_ext;
                        resp_err_q   <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state        <= RESP;
                    end
                end
                WR: begin
                    mem_w_enabled_q <= 1'b0;
                    resp_rdata_q    <= 32'd0;
                    resp_err_q      <= 1'b0;
                    resp_valid_q    <= 1'b1;
                    state           <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= 32'd0;
                        resp_err_q   <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    mem_r_enabled_q <= 1'b0;
                    mem_w_enabled_q <= 1'b0;
                    resp_valid_q    <= 1'b0;
                    req_ready_q     <= 1'b1;
                    state           <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_rdata    = resp_rdata_q;
    assign bus.resp_err      = resp_err_q;
    assign bus.mem_base      = mem_base_q;
    assign bus.mem_offset    = 32'd0;
    assign bus.mem_r_enabled = mem_r_enabled_q;
    assign bus.mem_w_enabled = mem_w_enabled_q;
    assign bus.mem_w_data    = mem_w_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Directed bench for load_store_unit with a word memory model, an
//   expected-response queue filled at issue time and a monitor that pops
//   and compares on every response handshake. Expectations follow the
//   LSU_MISALIGN_CHECK_EN setting of the build.
module tb_load_store_unit;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit #(.MEM_WORDS(1024)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [31:0] mem [0:1023];
    logic [31:0] mem_rdata_q;

    always @(posedge clk) begin
        if (bus.mem_w_enabled) mem[bus.mem_base[11:2]] <= bus.mem_w_data;
        if (bus.mem_r_enabled) mem_rdata_q <= mem[bus.mem_base[11:2]];
    end
    assign bus.mem_r_data = mem_rdata_q;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rstn && bus.resp_valid && bus.resp_ready) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_resp: got rdata 0x%08h err %0b expected no response",
                         bus.resp_rdata, bus.resp_err);
            end else begin
                e = sb.pop_front();
                check("resp_rdata", bus.resp_rdata, e.rdata);
                check("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for one cycle; returns #1 after the accept edge (cycle N+1).
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] base,
                         input logic [31:0] off, input logic [31:0] wd,
                         input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb.push_back(e);
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_base     = base;
        bus.req_offset   = off;
        bus.req_wdata    = wd;
        bus.req_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && !bus.req_ready; i++) cyc();
        if (!bus.req_ready) begin
            n_total++;
            $display("FAIL wait_idle: got req_ready 0 expected 1 within 20 cycles");
        end
    endtask

    task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] off, input logic [31:0] wd,
                       input logic [31:0] exp_rdata, input logic exp_err);
        issue(st, f3, base, off, wd, exp_rdata, exp_err);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem_rdata_q      = 32'd0;
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = 3'd0;
        bus.req_base     = 32'd0;
        bus.req_offset   = 32'd0;
        bus.req_wdata    = 32'd0;
        bus.resp_ready   = 1'b1;

        // Reset
        repeat (3) cyc();
        rstn = 1'b1;
        cyc();
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_strobes", {30'd0, bus.mem_r_enabled, bus.mem_w_enabled}, 32'd0);
        check("rst_mem_offset", bus.mem_offset, 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);

        // SW then LW with cycle timing
        issue(1'b1, 3'b010, 32'h100, 32'd4, 32'hDEADBEEF, 32'd0, 1'b0);
        check("sw_n1_w_en", {31'd0, bus.mem_w_enabled}, 32'd1);
        check("sw_n1_r_en", {31'd0, bus.mem_r_enabled}, 32'd0);
        check("sw_n1_base", bus.mem_base, 32'h104);
        check("sw_n1_w_data", bus.mem_w_data, 32'hDEADBEEF);
        check("sw_n1_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        cyc();
        check("sw_n2_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
        wait_idle();

        issue(1'b0, 3'b010, 32'h100, 32'd4, 32'd0, 32'hDEADBEEF, 1'b0);
        check("lw_n1_r_en", {31'd0, bus.mem_r_enabled}, 32'd1);
        check("lw_n1_base", bus.mem_base, 32'h104);
        cyc();
        check("lw_n2_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        cyc();
        check("lw_n3_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
        wait_idle();

        // SB read-modify-write timing
        issue(1'b1, 3'b000, 32'h104, 32'd1, 32'h000000AA, 32'd0, 1'b0);
        check("sb_n1_strobes", {30'd0, bus.mem_r_enabled, bus.mem_w_enabled}, 32'd2);
        cyc();
        check("sb_n2_strobes", {30'd0, bus.mem_r_enabled, bus.mem_w_enabled}, 32'd0);
        check("sb_n2_base", bus.mem_base, 32'h104);
        cyc();
        check("sb_n3_strobes", {30'd0, bus.mem_r_enabled, bus.mem_w_enabled}, 32'd1);
        check("sb_n3_w_data", bus.mem_w_data, 32'hDEADAAEF);
        check("sb_n3_base", bus.mem_base, 32'h104);
        check("sb_n3_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        cyc();
        check("sb_n4_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
        wait_idle();
        run(1'b0, 3'b000, 32'h105, 32'd0, 32'd0, 32'hFFFFFFAA, 1'b0);
        run(1'b0, 3'b100, 32'h105, 32'd0, 32'd0, 32'h000000AA, 1'b0);

        // SH and halfword/byte loads
        run(1'b1, 3'b001, 32'h106, 32'd0, 32'h00001234, 32'd0, 1'b0);
        check("sh_mem_word", mem[65], 32'h1234AAEF);
        run(1'b0, 3'b001, 32'h106, 32'd0, 32'd0, 32'h00001234, 1'b0);
        run(1'b0, 3'b001, 32'h104, 32'd0, 32'd0, 32'hFFFFAAEF, 1'b0);
        run(1'b0, 3'b101, 32'h104, 32'd0, 32'd0, 32'h0000AAEF, 1'b0);
        run(1'b0, 3'b000, 32'h107, 32'd0, 32'd0, 32'h00000012, 1'b0);
        run(1'b0, 3'b010, 32'h108, 32'hFFFFFFFC, 32'd0, 32'h1234AAEF, 1'b0);
        run(1'b0, 3'b010, 32'hFFFFFFFC, 32'h108, 32'd0, 32'h1234AAEF, 1'b0);

        // Misalignment
        run(1'b1, 3'b010, 32'h100, 32'd0, 32'h0BADF00D, 32'd0, 1'b0);
`ifdef LSU_MISALIGN_CHECK_EN
        issue(1'b0, 3'b010, 32'h101, 32'd0, 32'd0, 32'd0, 1'b1);
        check("mis_n1_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
        check("mis_n1_strobes", {30'd0, bus.mem_r_enabled, bus.mem_w_enabled}, 32'd0);
        wait_idle();
        run(1'b0, 3'b001, 32'h105, 32'd0, 32'd0, 32'd0, 1'b1);
`else
        run(1'b0, 3'b010, 32'h101, 32'd0, 32'd0, 32'h0BADF00D, 1'b0);
        run(1'b0, 3'b001, 32'h105, 32'd0, 32'd0, 32'hFFFFAAEF, 1'b0);
`endif

        // Range and illegal funct3
        issue(1'b0, 3'b010, 32'h1000, 32'd0, 32'd0, 32'd0, 1'b1);
        check("oor_n1_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
        check("oor_n1_strobes", {30'd0, bus.mem_r_enabled, bus.mem_w_enabled}, 32'd0);
        wait_idle();
        run(1'b1, 3'b000, 32'hFF0, 32'h10, 32'h00000077, 32'd0, 1'b1);
        run(1'b1, 3'b010, 32'hFFC, 32'd0, 32'h11223344, 32'd0, 1'b0);
        run(1'b0, 3'b010, 32'hFFC, 32'd0, 32'd0, 32'h11223344, 1'b0);
        run(1'b0, 3'b011, 32'h104, 32'd0, 32'd0, 32'd0, 1'b1);
        run(1'b1, 3'b100, 32'h104, 32'd0, 32'h000000FF, 32'd0, 1'b1);
        run(1'b0, 3'b110, 32'h104, 32'd0, 32'd0, 32'd0, 1'b1);
        check("illegal_no_write", mem[65], 32'h1234AAEF);

        // Back-pressure: response held, new request refused
        bus.resp_ready = 1'b0;
        issue(1'b0, 3'b010, 32'h104, 32'd0, 32'd0, 32'h1234AAEF, 1'b0);
        cyc();
        cyc();
        bus.req_is_store = 1'b0;
        bus.req_funct3   = 3'b010;
        bus.req_base     = 32'h100;
        bus.req_offset   = 32'd0;
        bus.req_valid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
            check("hold_resp_rdata", bus.resp_rdata, 32'h1234AAEF);
            check("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
            cyc();
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        wait_idle();
        repeat (3) cyc();

        // Reset during WR abandons the store
        issue(1'b1, 3'b010, 32'h104, 32'd0, 32'h55555555, 32'd0, 1'b0);
        void'(sb.pop_back());
        check("wr_w_en_before_rst", {31'd0, bus.mem_w_enabled}, 32'd1);
        rstn = 1'b0;
        #1;
        check("rst_in_wr_w_en", {31'd0, bus.mem_w_enabled}, 32'd0);
        check("rst_in_wr_req_ready", {31'd0, bus.req_ready}, 32'd1);
        cyc();
        cyc();
        rstn = 1'b1;
        cyc();
        check("rst_in_wr_mem_word", mem[65], 32'h1234AAEF);
        run(1'b0, 3'b010, 32'h104, 32'd0, 32'd0, 32'h1234AAEF, 1'b0);

        repeat (2) cyc();
        check("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
